// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable reference-clock divider.
// State codes and the config validity rule live here.
package clkdiv_pkg;

    localparam int DEF_CNT_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;
    localparam logic [1:0] ST_STOP = 2'd3;

    // A ratio is usable only if both the high and the low phase are non-empty.
    function automatic logic cfg_ok(input logic [31:0] d, input logic [31:0] h);
        return (d >= 32'd2) && (h != 32'd0) && (h < d);
    endfunction

endpackage

// File: rtl/clkdiv_core.sv
// Period counter with registered divided clock and period strobe.
// The count restarts at zero whenever the block is (re)enabled.
module clkdiv_core #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    input  logic [CNT_W-1:0] high,
    output logic             wrap,
    output logic             div_clk_out,
    output logic             period_strobe
);

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             stb_q, stb_d;

    assign wrap          = active_q && (cnt_q == div - CNT_W'(1));
    assign div_clk_out   = out_q;
    assign period_strobe = stb_q;

    always_comb begin
        cnt_d = '0;
        if (en && active_q && !wrap) cnt_d = cnt_q + CNT_W'(1);
        active_d = en;
        out_d    = en && (cnt_d < high);
        stb_d    = en && (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            out_q    <= 1'b0;
            stb_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            stb_q    <= stb_d;
        end
    end

endmodule

// File: rtl/clock_divider_sequencer.sv
// Run/stop sequencing and ratio handshake around the divider core.
// New ratios only reach the core on a period boundary or while idle.
module clock_divider_sequencer
    import clkdiv_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int DEFAULT_DIV  = 5,
    parameter int DEFAULT_HIGH = 2
) (
    input  logic             FiftyMHz_ref_clock,
    input  logic             reset,
    input  logic             run,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_err,
    output logic             div_clk_out,
    output logic             period_strobe,
    output logic             running
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic [CNT_W-1:0] pend_high_q, pend_high_d;
    logic             pend_vld_q, pend_vld_d;
    logic             err_q, err_d;
    logic             wrap, en, idle, accept, load, apply;

    assign cfg_ready = (state_q != ST_PEND);
    assign running   = (state_q != ST_IDLE);
    assign cfg_err   = err_q;

    always_comb begin
        idle   = (state_q == ST_IDLE);
        accept = cfg_valid && cfg_ready;
        load   = accept && cfg_ok(32'(cfg_div), 32'(cfg_high));
        apply  = pend_vld_q && (wrap || idle);
        err_d  = accept && !load;

        div_d       = div_q;
        high_d      = high_q;
        pend_div_d  = pend_div_q;
        pend_high_d = pend_high_q;
        pend_vld_d  = pend_vld_q;

        if (apply) begin
            div_d      = pend_div_q;
            high_d     = pend_high_q;
            pend_vld_d = 1'b0;
        end
        // While counting, a new ratio must wait for the next wrap.
        if (load && idle) begin
            div_d  = cfg_div;
            high_d = cfg_high;
        end else if (load) begin
            pend_div_d  = cfg_div;
            pend_high_d = cfg_high;
            pend_vld_d  = 1'b1;
        end

        if (idle)
            state_d = run ? ST_RUN : ST_IDLE;
        else if (!run)
            state_d = wrap ? ST_IDLE : ST_STOP;
        else
            state_d = pend_vld_d ? ST_PEND : ST_RUN;

        en = (state_d != ST_IDLE);
    end

    always_ff @(posedge FiftyMHz_ref_clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            div_q       <= CNT_W'(DEFAULT_DIV);
            high_q      <= CNT_W'(DEFAULT_HIGH);
            pend_div_q  <= '0;
            pend_high_q <= '0;
            pend_vld_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            high_q      <= high_d;
            pend_div_q  <= pend_div_d;
            pend_high_q <= pend_high_d;
            pend_vld_q  <= pend_vld_d;
            err_q       <= err_d;
        end
    end

    clkdiv_core #(
        .CNT_W(CNT_W)
    ) u_core (
        .clk          (FiftyMHz_ref_clock),
        .rst          (reset),
        .en           (en),
        .div          (div_q),
        .high         (high_q),
        .wrap         (wrap),
        .div_clk_out  (div_clk_out),
        .period_strobe(period_strobe)
    );

endmodule

// File: tb/tb_clock_divider_sequencer.sv
// Randomised and directed bench for the divider sequencer.
// A period-level model predicts every output on every reference cycle.
module tb_clock_divider_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_div = '0;
    logic [7:0] cfg_high = '0;
    logic       cfg_ready, cfg_err, div_clk_out, period_strobe, running;

    int checks = 0;
    int errors = 0;

    // Model: position inside the current output period plus the ratios.
    bit m_active, m_pvld, m_err, m_lastrun;
    int m_p, m_div, m_high, m_pdiv, m_phigh;

    logic [4:0] obs, exp_v;

    clock_divider_sequencer dut (
        .FiftyMHz_ref_clock(clk),
        .reset            (reset),
        .run              (run),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_div          (cfg_div),
        .cfg_high         (cfg_high),
        .cfg_err          (cfg_err),
        .div_clk_out      (div_clk_out),
        .period_strobe    (period_strobe),
        .running          (running)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_active = 0; m_pvld = 0; m_err = 0; m_lastrun = 0;
        m_p = 0; m_div = 5; m_high = 2; m_pdiv = 0; m_phigh = 0;
    endtask

    function automatic bit m_ready();
        return !(m_active && m_pvld && m_lastrun);
    endfunction

    task automatic model_step();
        bit acc, ok, last;
        if (reset) begin
            model_reset();
            return;
        end
        acc = cfg_valid && m_ready();
        ok = (cfg_div >= 2) && (cfg_high >= 1) && (cfg_high < cfg_div);
        m_err = acc && !ok;
        if (!m_active) begin
            if (m_pvld) begin
                m_div = m_pdiv; m_high = m_phigh; m_pvld = 0;
            end
            if (acc && ok) begin
                m_div = cfg_div; m_high = cfg_high;
            end
            if (run) begin
                m_active = 1; m_p = 0;
            end
        end else begin
            last = (m_p == m_div - 1);
            if (last) begin
                if (m_pvld) begin
                    m_div = m_pdiv; m_high = m_phigh; m_pvld = 0;
                end
                m_p = 0;
                if (!run) m_active = 0;
            end else begin
                m_p++;
            end
            if (acc && ok) begin
                m_pdiv = cfg_div; m_phigh = cfg_high; m_pvld = 1;
            end
        end
        m_lastrun = run;
    endtask

    function automatic logic [4:0] exp_vec();
        return {m_active && (m_p < m_high), m_active && (m_p == 0),
                m_active, m_ready(), m_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_pos(input int p, input string nm);
        int n = 0;
        while (!(m_active && m_p == p) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (!(m_active && m_p == p)) begin
            errors++;
            $display("FAIL %s timeout got pos %0d exp %0d", nm, m_p, p);
        end
    endtask

    task automatic test_reset();
        reset = 1; run = 0; cfg_valid = 0;
        tick(); tick();
        obs = {div_clk_out, period_strobe, running, cfg_ready, cfg_err};
        checks++;
        if (obs !== 5'b00010) begin
            errors++;
            $display("FAIL reset_vals got %b exp %b", obs, 5'b00010);
        end
        reset = 0;
        tick();
        obs = {div_clk_out, period_strobe, running, cfg_ready, cfg_err};
        exp_v = exp_vec();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_idle got %b exp %b", obs, exp_v);
        end
    endtask

    task automatic test_defaults();
        logic [14:0] pat;
        run = 1;
        for (int i = 0; i < 15; i++) begin
            tick();
            pat[14-i] = div_clk_out;
            obs = {div_clk_out, period_strobe, running, cfg_ready, cfg_err};
            exp_v = exp_vec();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL defaults cyc %0d got %b exp %b", i, obs, exp_v);
            end
        end
        checks++;
        if (pat !== 15'b110001100011000) begin
            errors++;
            $display("FAIL default_pattern got %b exp %b", pat, 15'b110001100011000);
        end
    endtask

    task automatic test_reconfig();
        wait_pos(1, "reconfig_sync");
        cfg_valid = 1; cfg_div = 10; cfg_high = 5;
        tick();
        cfg_valid = 0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL reconfig_ready got %b exp 0", cfg_ready);
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            obs = {div_clk_out, period_strobe, running, cfg_ready, cfg_err};
            exp_v = exp_vec();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reconfig cyc %0d got %b exp %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_reject();
        cfg_valid = 1; cfg_div = 4; cfg_high = 4;
        tick();
        cfg_div = 1; cfg_high = 0;
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL reject_err got %b exp 1", cfg_err);
        end
        for (int i = 0; i < 14; i++) begin
            tick();
            cfg_valid = 0;
            obs = {div_clk_out, period_strobe, running, cfg_ready, cfg_err};
            exp_v = exp_vec();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reject cyc %0d got %b exp %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_stop_restart();
        reset = 1; tick(); reset = 0;
        run = 1;
        wait_pos(1, "stop_sync");
        run = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            obs = {div_clk_out, period_strobe, running, cfg_ready, cfg_err};
            exp_v = exp_vec();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL stop cyc %0d got %b exp %b", i, obs, exp_v);
            end
        end
        checks++;
        if ({running, div_clk_out} !== 2'b00) begin
            errors++;
            $display("FAIL stopped got %b exp 00", {running, div_clk_out});
        end
        run = 1;
        tick();
        checks++;
        if ({div_clk_out, period_strobe} !== 2'b11) begin
            errors++;
            $display("FAIL restart got %b exp 11", {div_clk_out, period_strobe});
        end
    endtask

    task automatic test_cfg_and_stop();
        wait_pos(2, "cfgstop_sync");
        cfg_valid = 1; cfg_div = 6; cfg_high = 3; run = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            cfg_valid = 0;
            obs = {div_clk_out, period_strobe, running, cfg_ready, cfg_err};
            exp_v = exp_vec();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL cfgstop cyc %0d got %b exp %b", i, obs, exp_v);
            end
        end
        run = 1;
        for (int i = 0; i < 14; i++) begin
            tick();
            obs = {div_clk_out, period_strobe, running, cfg_ready, cfg_err};
            exp_v = exp_vec();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL newratio cyc %0d got %b exp %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        wait_pos(1, "areset_sync");
        #1;
        reset = 1;
        model_reset();
        #1;
        checks++;
        if (div_clk_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got %b exp 0", div_clk_out);
        end
        tick();
        reset = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            obs = {div_clk_out, period_strobe, running, cfg_ready, cfg_err};
            exp_v = exp_vec();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL post_reset cyc %0d got %b exp %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            run = ($urandom_range(0, 15) != 0);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_div = 8'($urandom_range(0, 12));
            cfg_high = 8'($urandom_range(0, 12));
            tick();
            obs = {div_clk_out, period_strobe, running, cfg_ready, cfg_err};
            exp_v = exp_vec();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random cyc %0d got %b exp %b", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_defaults();
        test_reconfig();
        test_reject();
        test_stop_restart();
        test_cfg_and_stop();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
